// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the BRAM_SDP stream reader.
// Optional feature macro used by this slice: BRAM_RD_STALL_CNT_EN.
`timescale 1ns/1ps

package bram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } bram_rd_state_t;

    localparam int unsigned BRAM_RD_BUF_DEPTH = 2;
    localparam int unsigned BRAM_RD_STALL_W   = 16;

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry FIFO that absorbs the BRAM read latency in front of the stream.
// The head entry drives dout and stays untouched until it is popped, which
// keeps the output word stable under backpressure.
`timescale 1ns/1ps

module bram_rd_skid
    import bram_rd_pkg::*;
#(
    parameter int unsigned DWIDTH = 36,
    parameter int unsigned CNT_W  = $clog2(BRAM_RD_BUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] din,
    input  logic              pop,
    output logic [DWIDTH-1:0] dout,
    output logic [CNT_W-1:0]  count
);

    logic [DWIDTH-1:0] entry [BRAM_RD_BUF_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Qualify push/pop against the current fill level.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CNT_W'(BRAM_RD_BUF_DEPTH)) || do_pop);
        dout    = entry[rd_ptr];
    end

    // Storage and pointers; simultaneous push and pop keep the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BRAM_RD_BUF_DEPTH; i++) begin
                entry[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                entry[wr_ptr] <= din;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_sdp_stream_reader.sv
// Read-side initiator for a BRAM_SDP instance: walks a contiguous, wrapping
// address range through the registered read port and presents the words as
// a valid/ready stream, one word per cycle at full downstream throughput.
// Define BRAM_RD_STALL_CNT_EN to add the stall_cnt backpressure counter.
`timescale 1ns/1ps

module bram_sdp_stream_reader
    import bram_rd_pkg::*;
#(
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned DWIDTH = 36
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [AWIDTH-1:0]          base,
    input  logic [AWIDTH:0]            len,
    output logic                       busy,
    output logic                       done,
    output logic                       rce,
    output logic [AWIDTH-1:0]          ra,
    input  logic [DWIDTH-1:0]          rq,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DWIDTH-1:0]          m_data
`ifdef BRAM_RD_STALL_CNT_EN
    ,
    output logic [BRAM_RD_STALL_W-1:0] stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(BRAM_RD_BUF_DEPTH + 1);

    bram_rd_state_t     state;
    logic [AWIDTH:0]    remaining;
    logic               inflight;
    logic [CNT_W-1:0]   buf_count;
    logic               pop;
    logic               accept;
    logic [CNT_W:0]     occ_next;
    logic               drain_empty;

    // Occupancy seen after this edge (buffer + pending push - pop) gates issue
    // and tells DRAIN when the last word has left.
    always_comb begin
        m_valid     = (buf_count != '0);
        pop         = m_valid && m_ready;
        accept      = (state == IDLE) && start;
        busy        = (state != IDLE);
        occ_next    = (CNT_W+1)'(buf_count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
        rce         = (state == RUN) && (remaining != '0) && (occ_next < (CNT_W+1)'(2));
        drain_empty = (occ_next == '0);
    end

    // Transfer FSM; done is registered so it coincides with busy falling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= (len == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (rce && (remaining == {{AWIDTH{1'b0}}, 1'b1})) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read address and remaining word count; address wraps with its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra        <= '0;
            remaining <= '0;
        end else if (accept) begin
            ra        <= base;
            remaining <= len;
        end else if (rce) begin
            ra        <= ra + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    // One read in flight at most; its data lands in the buffer next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rce;
        end
    end

    bram_rd_skid #(
        .DWIDTH (DWIDTH),
        .CNT_W  (CNT_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push   (inflight),
        .din    (rq),
        .pop    (pop),
        .dout   (m_data),
        .count  (buf_count)
    );

`ifdef BRAM_RD_STALL_CNT_EN
    // Saturating count of backpressured cycles in the current transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (m_valid && !m_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/bram_sdp_stream_reader.md
# bram_sdp_stream_reader

Read-side initiator for the simple-dual-port block RAM (BRAM_SDP family). On a start command it walks a contiguous address range through the BRAM read port (`rce`/`ra`/`rq`, one-cycle registered read) and presents the words as a valid/ready stream. A small output buffer absorbs the read latency, so the block sustains one word per cycle under full downstream throughput and never loses data under backpressure. It sits between a BRAM_SDP instance, whose write port is owned by a producer, and a streaming consumer.

## Interface
Parameters:
- `AWIDTH`, 10: BRAM address width; the memory depth is 2^AWIDTH.
- `DWIDTH`, 36: BRAM data width.

Ports:
- `clk` in 1: single clock, shared with the BRAM.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: transfer request; sampled only in IDLE.
- `base` in AWIDTH: first read address; latched when `start` is accepted.
- `len` in AWIDTH+1: word count, 0..2^AWIDTH; latched when `start` is accepted.
- `busy` out 1: high while a transfer is in progress.
- `done` out 1: one-cycle pulse at the end of a transfer.
- `rce` out 1: BRAM read enable.
- `ra` out AWIDTH: BRAM read address.
- `rq` in DWIDTH: BRAM read data, valid in the cycle after `rce`; the BRAM holds it while `rce` is low.
- `m_valid` out 1, `m_ready` in 1, `m_data` out DWIDTH: output stream.

## Operation
- FSM states:
  - IDLE -> RUN on `start`.
  - RUN -> DRAIN when the last read has been issued.
  - DRAIN -> IDLE when the buffer is empty and no read is in flight; `done` pulses in that cycle.
- `start` with `len`=0: IDLE -> DRAIN -> IDLE. `done` pulses one cycle after acceptance. No `rce` is issued.
- `start` is ignored while `busy` is high. `base` and `len` are not re-sampled during a transfer.
- Read issue:
  - `rce`=1 when in RUN, remaining>0, and (buffer count + inflight − pop this cycle) < 2.
  - Each issue advances `ra` by 1.
- Address wraps modulo 2^AWIDTH. Example: `base`=0x3FE, `len`=4 reads 0x3FE, 0x3FF, 0x000, 0x001.
- `inflight` is a 1-bit flag set by `rce`. On the following edge `rq` is written into the buffer and `inflight` clears.
- Buffer:
  - 2-entry FIFO; `m_data` comes from the head entry.
  - Push and pop in the same cycle are legal.
  - Stream rule: `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- Words are emitted in address order, exactly `len` words per transfer, with no duplicates.
- `busy` = (state != IDLE). It falls in the same cycle `done` pulses.
- Reset values, applied asynchronously: state IDLE; `busy`, `done`, `rce`, `m_valid`, `inflight`, buffer count = 0; `ra`, `m_data` = 0.
- Reset mid-transfer aborts the transfer immediately: buffered data is discarded and no `done` pulse is produced.

## Timing
- Cycle 0: `start`=1 is sampled at the edge.
- Cycle 1: `rce`=1, `ra`=`base`.
- Cycle 2: `rq` is valid and is pushed into the buffer at the edge.
- Cycle 3: `m_valid`=1. Start-to-first-data latency is therefore 3 cycles.
- With `m_ready` held at 1, one word per cycle. The last word is accepted in cycle `len`+2 and `done` pulses in cycle `len`+3.
- When `m_ready` drops, at most 2 further words are buffered (1 already buffered + 1 in flight). `rce` then stays low until a pop occurs.
- `rce` is never asserted while the buffer is full and nothing is being popped.

## Configuration
- `BRAM_RD_STALL_CNT_EN`
- Defined:
  - Adds output `stall_cnt` [15:0]: counts cycles with `m_valid`=1 and `m_ready`=0 during the current transfer.
  - Cleared to 0 when `start` is accepted and on reset.
  - Saturates at 0xFFFF and holds its value after `done`.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

## Structure
- Package `bram_rd_pkg`:
  - state typedef `bram_rd_state_t` {IDLE, RUN, DRAIN};
  - `BRAM_RD_BUF_DEPTH` = 2;
  - `BRAM_RD_STALL_W` = 16.
- Sub-module `bram_rd_skid`: the 2-entry FIFO with push/pop/count, reset to empty.
- The top level contains the FSM, the address and remaining counters, the inflight flag and the optional stall counter.

## Test plan
- Reset, then `start` with `base`=0x010, `len`=8, `m_ready`=1. Memory preloaded with data = address. Expect:
  - `m_data` 0x010..0x017 on consecutive cycles 3..10;
  - `done` in cycle 11;
  - `busy` high in cycles 1..10.
- `base`=0x3FE, `len`=4 -> reads from 0x3FE, 0x3FF, 0x000, 0x001, in that order.
- `len`=0 -> no `rce`, no `m_valid`, `done` one cycle after acceptance.
- `len`=16 with `m_ready` toggling as 1,0,0,1,0,... Expect:
  - all 16 words in order, with no drops or duplicates;
  - `rce` never asserted while the buffer is full and no pop occurs;
  - with `BRAM_RD_STALL_CNT_EN`, `stall_cnt` equals the count of stall cycles.
- `start` pulsed again mid-transfer -> ignored: the word count stays at the original `len` and exactly one `done` is produced.
- `rst` asserted in the middle of a `len`=32 transfer -> all outputs drop to 0 asynchronously and no `done` follows. A new `start` then runs cleanly from its `base`.
